// File: rtl/msb_pkg.sv
// Shared types and default widths for the multi-stream buffer read scheduler.
package msb_pkg;

  localparam int MSB_NREQ = 4;
  localparam int MSB_ST_W = 4;
  localparam int MSB_CL_W = 4;
  localparam int MSB_OF_W = 3;
  localparam int ID_W     = (MSB_NREQ > 1) ? $clog2(MSB_NREQ) : 1;

  // One latched burst request: where to read and how many beats (len = beats-1).
  typedef struct packed {
    logic [MSB_ST_W-1:0] st;
    logic [MSB_CL_W-1:0] cl;
    logic [MSB_OF_W-1:0] of;
    logic [MSB_OF_W-1:0] len;
  } rd_req_t;

  // Travels with each issued beat so the in-order response can be routed back.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
  } rd_tag_t;

  typedef enum logic {IDLE, BURST} sched_state_e;

endpackage

// File: rtl/msb_tag_fifo.sv
// Tag FIFO holding one entry per beat issued to the buffer and not yet returned.
// Push and pop may happen together, including when full.
module msb_tag_fifo
  import msb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  rd_tag_t       push_tag,
  input  logic          pop,
  output rd_tag_t       head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  rd_tag_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Tag storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/msb_rd_sched.sv
// Read scheduler: round-robin arbitration of burst requests, per-beat address
// expansion toward the buffer read port, and in-order response routing by tag.
module msb_rd_sched
  import msb_pkg::*;
#(
  parameter int NREQ    = MSB_NREQ,
  parameter int ST_W    = MSB_ST_W,
  parameter int CL_W    = MSB_CL_W,
  parameter int OF_W    = MSB_OF_W,
  parameter int DW      = 128,
  parameter int MAX_OUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   i_req_v,
  output logic [NREQ-1:0]   i_req_r,
  input  logic [NREQ*ST_W-1:0] i_req_st,
  input  logic [NREQ*CL_W-1:0] i_req_cl,
  input  logic [NREQ*OF_W-1:0] i_req_of,
  input  logic [NREQ*OF_W-1:0] i_req_len,
  output logic              o_ra_v,
  input  logic              o_ra_r,
  output logic [ST_W-1:0]   o_ra_st,
  output logic [CL_W-1:0]   o_ra_cl,
  output logic [OF_W-1:0]   o_ra_of,
  input  logic              i_rd_v,
  output logic              i_rd_r,
  input  logic [DW-1:0]     i_rd,
  output logic [NREQ-1:0]   o_rsp_v,
  input  logic [NREQ-1:0]   o_rsp_r,
  output logic [DW-1:0]     o_rsp_d,
  output logic              o_rsp_last,
  output logic              o_busy,
  output logic              o_err
);

  localparam int AW = $clog2(MAX_OUT);

  sched_state_e     state;
  rd_req_t          cur;
  logic [ID_W-1:0]  cur_id;
  logic [OF_W-1:0]  beat;
  logic [ID_W-1:0]  rr_ptr;

  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic [NREQ-1:0]  grant_oh;

  rd_tag_t          head;
  logic [AW:0]      tag_count;
  logic             tag_full;
  logic             tag_empty;
  logic             ra_fire;
  logic             last_beat;
  logic             rd_pop;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = rr_ptr;
    grant_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!grant_found && i_req_v[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
    if (grant_found) grant_oh[grant_id] = 1'b1;
  end

  assign i_req_r   = (state == IDLE) ? grant_oh : '0;

  assign o_ra_v    = (state == BURST) && !tag_full;
  assign o_ra_st   = cur.st;
  assign o_ra_cl   = cur.cl;
  assign o_ra_of   = cur.of + beat;
  assign ra_fire   = o_ra_v && o_ra_r;
  assign last_beat = (beat == cur.len);

  // Burst FSM: latch a granted request, then walk its beats until the last is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cur    <= '0;
      cur_id <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cur.st <= i_req_st[int'(grant_id)*ST_W +: ST_W];
            cur.cl <= i_req_cl[int'(grant_id)*CL_W +: CL_W];
            cur.of <= i_req_of[int'(grant_id)*OF_W +: OF_W];
            cur.len <= i_req_len[int'(grant_id)*OF_W +: OF_W];
            cur_id <= grant_id;
            beat   <= '0;
            rr_ptr <= (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
            state  <= BURST;
          end
        end
        BURST: begin
          if (ra_fire) begin
            beat <= beat + 1'b1;
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  msb_tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (ra_fire),
    .push_tag ({cur_id, last_beat}),
    .pop      (rd_pop),
    .head     (head),
    .count    (tag_count),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // Response demux: the head tag says which requester owns the returning beat.
  always_comb begin
    o_rsp_v = '0;
    for (int k = 0; k < NREQ; k++) begin
      o_rsp_v[k] = i_rd_v && !tag_empty && (head.id == ID_W'(k));
    end
  end

  assign o_rsp_d    = i_rd;
  assign o_rsp_last = head.last;
  assign i_rd_r     = tag_empty ? i_rd_v : o_rsp_r[head.id];
  assign rd_pop     = i_rd_v && i_rd_r && !tag_empty;
  assign o_busy     = (state == BURST) || (tag_count != '0);

  // Sticky error: a response showed up when nothing was outstanding.
  always_ff @(posedge clk) begin
    if (reset)                      o_err <= 1'b0;
    else if (i_rd_v && tag_empty)   o_err <= 1'b1;
  end

endmodule
